// File: rtl/edge_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : edge_event_monitor
//  Description : Samples a toggling signal, emits one-cycle edge pulses, keeps
//                saturating per-polarity edge counts and queues timestamped
//                edge events for a valid/ready consumer.
//                EDGE_EVENT_MONITOR_SYNC_EN selects a 2-flop input synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module edge_event_monitor #(
    parameter int TS_WIDTH   = 32,
    parameter int CNT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sig_in,
    input  logic                 clear,
    output logic                 pos_edge,
    output logic                 neg_edge,
    output logic                 any_edge,
    output logic [CNT_WIDTH-1:0] pos_count,
    output logic [CNT_WIDTH-1:0] neg_count,
    output logic [TS_WIDTH-1:0]  timestamp,
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic                 evt_pol,
    output logic [TS_WIDTH-1:0]  evt_time,
    output logic                 overflow
);

    localparam int                   c_addr_w  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int                   c_ptr_w   = c_addr_w + 1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;

    logic                 r_samp;
    logic                 r_prev;
    logic                 r_pos;
    logic                 r_neg;
    logic [CNT_WIDTH-1:0] r_pos_cnt;
    logic [CNT_WIDTH-1:0] r_neg_cnt;
    logic [TS_WIDTH-1:0]  r_ts;
    logic                 r_ovf;
    logic [TS_WIDTH:0]    r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [TS_WIDTH:0]    r_head;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push_acc;
    logic [c_ptr_w-1:0]   w_wr_next;
    logic [c_ptr_w-1:0]   w_rd_next;
    logic [TS_WIDTH:0]    w_head_next;

`ifdef EDGE_EVENT_MONITOR_SYNC_EN
    logic r_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_samp <= 1'b0;
        end else begin
            r_meta <= sig_in;
            r_samp <= r_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_samp <= 1'b0;
        end else begin
            r_samp <= sig_in;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b0;
            r_pos  <= 1'b0;
            r_neg  <= 1'b0;
        end else begin
            r_prev <= r_samp;
            r_pos  <= r_samp & ~r_prev;
            r_neg  <= ~r_samp & r_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_pos_cnt <= '0;
            r_neg_cnt <= '0;
        end else begin
            if (r_pos && (r_pos_cnt != c_cnt_max)) begin
                r_pos_cnt <= r_pos_cnt + CNT_WIDTH'(1);
            end
            if (r_neg && (r_neg_cnt != c_cnt_max)) begin
                r_neg_cnt <= r_neg_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign w_push     = r_pos | r_neg;
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]) &&
                        (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]);
    assign w_pop      = ~w_empty & evt_ready;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_push_acc = w_push & (~w_full | w_pop);
    assign w_wr_next  = r_wr_ptr + c_ptr_w'(w_push_acc);
    assign w_rd_next  = r_rd_ptr + c_ptr_w'(w_pop);

    // The new head is the incoming event only when it lands in the slot being exposed.
    always_comb begin
        w_head_next = r_mem[r_rd_next_idx()];
        if (w_push_acc && (r_wr_ptr[c_addr_w-1:0] == w_rd_next[c_addr_w-1:0])) begin
            w_head_next = {r_pos, r_ts};
        end
    end

    function automatic logic [c_addr_w-1:0] r_rd_next_idx();
        return w_rd_next[c_addr_w-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_head   <= '0;
            r_ovf    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_acc) begin
                r_mem[r_wr_ptr[c_addr_w-1:0]] <= {r_pos, r_ts};
            end
            r_wr_ptr <= w_wr_next;
            r_rd_ptr <= w_rd_next;
            if (w_wr_next != w_rd_next) begin
                r_head <= w_head_next;
            end
            if (clear) begin
                r_ovf <= 1'b0;
            end else if (w_push && w_full && !w_pop) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign pos_edge  = r_pos;
    assign neg_edge  = r_neg;
    assign any_edge  = r_pos | r_neg;
    assign pos_count = r_pos_cnt;
    assign neg_count = r_neg_cnt;
    assign timestamp = r_ts;
    assign evt_valid = ~w_empty;
    assign evt_pol   = r_head[TS_WIDTH];
    assign evt_time  = r_head[TS_WIDTH-1:0];
    assign overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edge_event_monitor
//  Description : Directed self-checking bench with a cycle model and an event
//                scoreboard for edge_event_monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edge_event_monitor;

    localparam int TSW   = 32;
    localparam int CW    = 4;
    localparam int DEPTH = 4;
`ifdef EDGE_EVENT_MONITOR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam logic [CW-1:0] CMAX = '1;

    logic           clk = 1'b0;
    logic           reset;
    logic           sig_in;
    logic           clear;
    logic           evt_ready;
    logic           pos_edge;
    logic           neg_edge;
    logic           any_edge;
    logic [CW-1:0]  pos_count;
    logic [CW-1:0]  neg_count;
    logic [TSW-1:0] timestamp;
    logic           evt_valid;
    logic           evt_pol;
    logic [TSW-1:0] evt_time;
    logic           overflow;

    always #5 clk = ~clk;

    edge_event_monitor #(
        .TS_WIDTH   (TSW),
        .CNT_WIDTH  (CW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sig_in    (sig_in),
        .clear     (clear),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .any_edge  (any_edge),
        .pos_count (pos_count),
        .neg_count (neg_count),
        .timestamp (timestamp),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_pol   (evt_pol),
        .evt_time  (evt_time),
        .overflow  (overflow)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Expected state of the design as seen in the current cycle.
    logic           e_pos = 1'b0;
    logic           e_neg = 1'b0;
    logic           e_ovf = 1'b0;
    logic [CW-1:0]  e_pc  = '0;
    logic [CW-1:0]  e_nc  = '0;
    logic [TSW-1:0] e_ts  = '0;
    logic           hh [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [TSW:0]   sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock: update the model from this cycle's inputs, then compare.
    task automatic step();
        logic pop;
        logic push;
        if (sb.size() != 0) begin
            chk("head", {31'd0, evt_pol, evt_time}, {31'd0, sb[0]});
        end
        pop  = (sb.size() != 0) && evt_ready;
        push = e_pos | e_neg;
        if (reset) begin
            e_pos = 1'b0; e_neg = 1'b0; e_ovf = 1'b0;
            e_pc  = '0;   e_nc  = '0;   e_ts  = '0;
            sb.delete();
            for (int i = 0; i < 4; i++) hh[i] = 1'b0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (push) begin
                if (sb.size() < DEPTH) sb.push_back({e_pos, e_ts});
                else e_ovf = 1'b1;
            end
            if (clear) begin
                e_pc = '0; e_nc = '0; e_ovf = 1'b0;
            end else begin
                if (e_pos && e_pc != CMAX) e_pc = e_pc + 1'b1;
                if (e_neg && e_nc != CMAX) e_nc = e_nc + 1'b1;
            end
            e_ts = e_ts + 1;
            for (int i = 3; i > 0; i--) hh[i] = hh[i-1];
            hh[0] = sig_in;
            e_pos = hh[LAT] & ~hh[LAT+1];
            e_neg = ~hh[LAT] & hh[LAT+1];
        end
        @(posedge clk);
        #1;
        chk("pos_edge",  64'(pos_edge),  64'(e_pos));
        chk("neg_edge",  64'(neg_edge),  64'(e_neg));
        chk("any_edge",  64'(any_edge),  64'(e_pos | e_neg));
        chk("pos_count", 64'(pos_count), 64'(e_pc));
        chk("neg_count", 64'(neg_count), 64'(e_nc));
        chk("timestamp", 64'(timestamp), 64'(e_ts));
        chk("evt_valid", 64'(evt_valid), 64'(sb.size() != 0));
        chk("overflow",  64'(overflow),  64'(e_ovf));
    endtask

    task automatic toggle(input int gap);
        sig_in = ~sig_in;
        repeat (gap) step();
    endtask

    // Steps until the model expects an edge pulse in the current cycle (bounded).
    task automatic to_pulse();
        int n;
        n = 0;
        while (!(e_pos | e_neg) && n < 10) begin
            step();
            n++;
        end
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        sig_in    = 1'b0;
        clear     = 1'b0;
        evt_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // clk/20 toggle, 10 rising edges, consumer always ready
        for (int i = 0; i < 20; i++) toggle(10);
        repeat (4) step();
        chk("t1_pos_count", 64'(pos_count), 64'd10);
        chk("t1_neg_count", 64'(neg_count), 64'd10);

        // sig_in high through reset reports one rising edge
        clear = 1'b1; step(); clear = 1'b0;
        sig_in = 1'b1;
        reset  = 1'b1; repeat (2) step(); reset = 1'b0;
        repeat (6) step();
        chk("t2_pos_count", 64'(pos_count), 64'd1);
        chk("t2_neg_count", 64'(neg_count), 64'd0);

        // overflow with a stalled consumer, then ordered drain
        evt_ready = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 6; i++) toggle(3);
        repeat (4) step();
        chk("t3_overflow", 64'(overflow), 64'd1);
        chk("t3_total", 64'(pos_count) + 64'(neg_count), 64'd6);
        evt_ready = 1'b1;
        repeat (8) step();
        chk("t3_drained", 64'(evt_valid), 64'd0);

        // full queue with push and pop in the same cycle
        evt_ready = 1'b0;
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 4; i++) toggle(3);
        repeat (3) step();
        sig_in = ~sig_in;
        to_pulse();
        evt_ready = 1'b1;
        step();
        chk("t4_overflow", 64'(overflow), 64'd0);
        repeat (8) step();

        // counter saturation, then clear coinciding with an edge
        clear = 1'b1; step(); clear = 1'b0;
        for (int i = 0; i < 34; i++) toggle(2);
        repeat (4) step();
        chk("t5_pos_sat", 64'(pos_count), 64'd15);
        chk("t5_neg_sat", 64'(neg_count), 64'd15);
        evt_ready = 1'b0;
        sig_in = ~sig_in;
        to_pulse();
        clear = 1'b1; step(); clear = 1'b0;
        chk("t5_clr_count", 64'(pos_count), 64'd0);
        chk("t5_clr_ovf",   64'(overflow),  64'd0);
        chk("t5_queued",    64'(evt_valid), 64'd1);
        chk("t5_pol",       64'(evt_pol),   64'd1);
        evt_ready = 1'b1;
        repeat (3) step();

        // reset mid-operation discards queued events
        evt_ready = 1'b0;
        toggle(4);
        toggle(4);
        sig_in = 1'b0;
        reset  = 1'b1; step();
        chk("t6_rst_valid", 64'(evt_valid), 64'd0);
        chk("t6_rst_pulse", 64'(any_edge),  64'd0);
        step(); reset = 1'b0;
        repeat (4) step();

        // rise-to-pulse latency
        evt_ready = 1'b1;
        sig_in = 1'b1;
        lat = 0;
        do begin
            step();
            lat++;
        end while (pos_edge !== 1'b1 && lat < 10);
        chk("latency", 64'(lat), 64'(LAT + 1));
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
